fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. Owns the program counter, drives the word address into the instruction memory, takes back its combinational read data, and registers instruction, PC and PC+4 into the IF/ID pipeline register for decode. It applies stall and flush requests from the hazard unit and branch/jump redirects from execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID on reset/flush.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_src_e  input  1  redirect request from execute (taken branch / jal / jalr).
- pc_target_e  input  32  redirect target address.
- stall_f  input  1  hold PC.
- stall_d  input  1  hold IF/ID register.
- flush_d  input  1  replace IF/ID contents with bubble.
- imem_addr  output  32  current PC_F, to instruction memory address.
- imem_rdata  input  32  instruction word, combinational from memory in the same cycle.
- instr_d  output  32  registered instruction.
- pc_d  output  32  registered PC of instr_d.
- pc_plus4_d  output  32  registered pc_d + 4.
- valid_d  output  1  1 = instr_d is a real fetched instruction, 0 = bubble.
- misalign_d  output  1  present only with FETCH_MISALIGN_CHECK_EN (see Configuration).

## Operation
- PC register update priority per edge: rst → RESET_PC; else pc_src_e → pc_target_e; else stall_f → hold; else PC_F + 4.
- Redirect beats stall_f: a redirect is never lost while fetch is stalled.
- PC+4 is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- imem_addr = PC_F directly, no registering; imem_rdata is sampled in the same cycle.
- IF/ID update priority: rst or flush_d → instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0 (misalign_d=0); else stall_d → hold all fields; else capture imem_rdata, PC_F, PC_F+4, valid_d=1.
- flush_d beats stall_d.
- No FSM beyond the PC and IF/ID registers; stage holds no other state.

## Timing
- Reset values (edge with rst=1): PC_F=RESET_PC, so imem_addr=RESET_PC in the following cycle; instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, misalign_d=0.
- First edge after rst deasserts: instr_d = mem[RESET_PC], pc_d = RESET_PC, valid_d=1; PC_F = RESET_PC+4.
- Fetch latency: instruction at PC_F=A appears on instr_d one cycle later (edge after A is presented).
- Redirect: pc_src_e sampled high at edge N → PC_F=pc_target_e after N; target instruction on instr_d after edge N+1. Wrong-path removal is the hazard unit's job via flush_d.
- Reset mid-operation: takes effect at the next edge regardless of stall/flush/redirect; no partial state kept.
- Stall: stall_f and stall_d both high for k cycles → imem_addr and all _d outputs constant for k cycles.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: on redirect with pc_target_e[1:0] != 0, PC loads {pc_target_e[31:2],2'b00} and a one-bit misalign_f flag is set with it; misalign_f clears on the next non-redirect PC update (PC+4) and on rst; misalign_d follows IF/ID capture/hold/flush rules like valid_d. Port misalign_d exists.
- Not defined: pc_target_e loaded unmodified (low bits pass through to pc_d; memory ignores them via word indexing); no misalign_f, no misalign_d port.

## Test plan
- Reset then free run, mem[0..2]=0x00500093,0x00A00113,0x002081B3 → after reset edge instr_d=0x00000013, valid_d=0; next three edges instr_d = those words with pc_d 0x0,0x4,0x8, pc_plus4_d 0x4,0x8,0xC.
- stall_f=stall_d=1 for 3 cycles at PC_F=0x8 → imem_addr stays 0x8, instr_d/pc_d frozen at pc_d=0x4; resumes 0x8 then 0xC.
- pc_src_e=1, pc_target_e=0x40 with stall_f=1 same cycle → PC_F=0x40 next cycle; flush_d=1 with stall_d=1 → instr_d=0x00000013, valid_d=0.
- PC forced to 0xFFFF_FFFC via redirect → next PC_F=0x0000_0000, pc_plus4_d for that fetch = 0x0.
- rst asserted mid-stall with pending redirect → next cycle PC_F=RESET_PC, all _d outputs at reset values.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x42 → imem_addr=0x40, instr_d captured with misalign_d=1, next fetch (0x44) misalign_d=0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V instruction fetch: PC register, imem address, IF/ID pipeline register.
// Optional FETCH_MISALIGN_CHECK_EN: word-aligns redirect targets and flags them via misalign_d.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_d
`endif
);

    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [31:0] redirect_pc;

    // Sequential increment wraps modulo 2^32 with no overflow indication.
    assign pc_plus4_f = pc_f + 32'd4;
    assign imem_addr  = pc_f;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_f;
    logic target_misaligned;

    assign target_misaligned = |pc_target_e[1:0];
    assign redirect_pc       = {pc_target_e[31:2], 2'b00};

    // Flag travels with the PC it describes: set on a misaligned redirect,
    // cleared by the next sequential advance, held while fetch is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_f <= 1'b0;
        end else if (pc_src_e) begin
            misalign_f <= target_misaligned;
        end else if (!stall_f) begin
            misalign_f <= 1'b0;
        end
    end
`else
    assign redirect_pc = pc_target_e;
`endif

    // Redirect outranks stall_f so a taken branch is never dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_PC;
        end else if (pc_src_e) begin
            pc_f <= redirect_pc;
        end else if (!stall_f) begin
            pc_f <= pc_plus4_f;
        end
    end

    // Flush outranks stall_d; a bubble carries zeroed PC fields.
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= 32'd0;
            pc_plus4_d <= 32'd0;
            valid_d    <= 1'b0;
        end else if (!stall_d) begin
            instr_d    <= imem_rdata;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= 1'b1;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            misalign_d <= 1'b0;
        end else if (!stall_d) begin
            misalign_d <= misalign_f;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed-vector bench for fetch_stage with a combinational instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_d;
`endif

    logic [31:0] mem [0:63];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_d  (misalign_d)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        rst         = 1'b0;
        pc_src_e    = 1'b0;
        pc_target_e = 32'd0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_instr"}, instr_d, 32'h0000_0013);
        check({tag, "_pc"}, pc_d, 32'h0);
        check({tag, "_pc4"}, pc_plus4_d, 32'h0);
        check({tag, "_valid"}, {31'd0, valid_d}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check({tag, "_mis"}, {31'd0, misalign_d}, 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;

        idle_inputs();
        rst = 1'b1;
        tick();
        check("rst_addr", imem_addr, 32'h0);
        check_bubble("rst");

        rst = 1'b0;
        tick();
        check("f0_instr", instr_d, 32'h0050_0093);
        check("f0_pc", pc_d, 32'h0);
        check("f0_pc4", pc_plus4_d, 32'h4);
        check("f0_valid", {31'd0, valid_d}, 32'd1);
        check("f0_addr", imem_addr, 32'h4);
        tick();
        check("f1_instr", instr_d, 32'h00A0_0113);
        check("f1_pc", pc_d, 32'h4);
        check("f1_pc4", pc_plus4_d, 32'h8);
        check("f1_addr", imem_addr, 32'h8);

        stall_f = 1'b1;
        stall_d = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_addr", imem_addr, 32'h8);
            check("stall_pc", pc_d, 32'h4);
            check("stall_instr", instr_d, 32'h00A0_0113);
        end
        idle_inputs();
        tick();
        check("f2_instr", instr_d, 32'h0020_81B3);
        check("f2_pc", pc_d, 32'h8);
        check("f2_pc4", pc_plus4_d, 32'hC);
        check("f2_addr", imem_addr, 32'hC);
        tick();
        check("f3_instr", instr_d, 32'hA000_0003);
        check("f3_pc", pc_d, 32'hC);
        check("f3_addr", imem_addr, 32'h10);

        pc_src_e    = 1'b1;
        pc_target_e = 32'h40;
        stall_f     = 1'b1;
        stall_d     = 1'b1;
        flush_d     = 1'b1;
        tick();
        check("redir_addr", imem_addr, 32'h40);
        check_bubble("flush");
        idle_inputs();
        tick();
        check("tgt_instr", instr_d, 32'hA000_0010);
        check("tgt_pc", pc_d, 32'h40);
        check("tgt_pc4", pc_plus4_d, 32'h44);
        check("tgt_valid", {31'd0, valid_d}, 32'd1);
        check("tgt_addr", imem_addr, 32'h44);

        pc_src_e    = 1'b1;
        pc_target_e = 32'hFFFF_FFFC;
        tick();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        check("top_prev_pc", pc_d, 32'h44);
        idle_inputs();
        tick();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc", pc_d, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4_d, 32'h0);
        check("wrap_instr", instr_d, 32'hA000_003F);
        tick();
        check("wrap_next_pc", pc_d, 32'h0);
        check("wrap_next_instr", instr_d, 32'h0050_0093);

        stall_f     = 1'b1;
        stall_d     = 1'b1;
        tick();
        pc_src_e    = 1'b1;
        pc_target_e = 32'h80;
        rst         = 1'b1;
        tick();
        check("rst2_addr", imem_addr, 32'h0);
        check_bubble("rst2");
        idle_inputs();
        tick();
        check("rst2_instr", instr_d, 32'h0050_0093);
        check("rst2_valid", {31'd0, valid_d}, 32'd1);
        check("rst2_next_addr", imem_addr, 32'h4);

        pc_src_e    = 1'b1;
        pc_target_e = 32'h42;
        tick();
        idle_inputs();
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_addr", imem_addr, 32'h40);
        check("mis_prev", {31'd0, misalign_d}, 32'd0);
        tick();
        check("mis_instr", instr_d, 32'hA000_0010);
        check("mis_pc", pc_d, 32'h40);
        check("mis_flag", {31'd0, misalign_d}, 32'd1);
        check("mis_next_addr", imem_addr, 32'h44);
        tick();
        check("mis_clr_pc", pc_d, 32'h44);
        check("mis_clr_flag", {31'd0, misalign_d}, 32'd0);
`else
        check("odd_addr", imem_addr, 32'h42);
        tick();
        check("odd_instr", instr_d, 32'hA000_0010);
        check("odd_pc", pc_d, 32'h42);
        check("odd_pc4", pc_plus4_d, 32'h46);
        check("odd_next_addr", imem_addr, 32'h46);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
